// File: rtl/ble_packet_tx.sv
// BLE 1M uncoded link-layer transmitter: preamble, access address, whitened PDU and CRC-24,
// serialised one symbol per SAMPLE_RATE clocks with a matching symbol clock.
module ble_packet_tx #(
    parameter int SAMPLE_RATE   = 16,
    parameter int MAX_PDU_BYTES = 39
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       en,
    input  logic                       start,
    input  logic [31:0]                acc_addr,
    input  logic [5:0]                 channel,
    input  logic [23:0]                crc_init,
    input  logic [8*MAX_PDU_BYTES-1:0] pdu_in,
    input  logic [5:0]                 pdu_len,
    output logic                       busy,
    output logic                       tx_bit,
    output logic                       tx_sym_clk,
    output logic                       done,
    output logic                       len_err
);

    localparam int          SYM_W   = (SAMPLE_RATE > 2) ? $clog2(SAMPLE_RATE) : 1;
    localparam int          BIT_W   = ($clog2(8*MAX_PDU_BYTES) > 5) ? $clog2(8*MAX_PDU_BYTES) : 5;
    localparam logic [6:0]  MAX_LEN = 7'(MAX_PDU_BYTES);
    localparam logic [23:0] POLY    = 24'h00065B;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ACCESS,
        PDU,
        CRC
    } state_t;

    state_t                     state, state_n, emit_state;
    logic [SYM_W-1:0]           sym_cnt, sym_n;
    logic [BIT_W-1:0]           bit_cnt, bit_n, emit_idx, pdu_last;
    logic [31:0]                aa_q;
    logic [8*MAX_PDU_BYTES-1:0] pdu_q;
    logic [5:0]                 len_q;
    logic [23:0]                crc, crc_n, crc_shift;
    logic [6:0]                 w, w_n, w_adv;
    logic                       tx_n, busy_n, done_n, len_err_n, load, finish;
    logic                       sym_last, len_ok, pdu_d;

    assign sym_last   = (sym_cnt == SYM_W'(SAMPLE_RATE - 1));
    assign pdu_last   = BIT_W'({len_q, 3'b000}) - BIT_W'(1);
    assign len_ok     = (pdu_len >= 6'd2) && ({1'b0, pdu_len} <= MAX_LEN);
    assign w_adv      = {1'b0, w[6:1]} ^ (w[0] ? 7'h44 : 7'h00);
    assign crc_shift  = {crc[22:0], 1'b0};
    assign pdu_d      = pdu_q[emit_idx];
    assign tx_sym_clk = busy && (sym_cnt < SYM_W'(SAMPLE_RATE / 2));

    always_comb begin
        state_n    = state;
        sym_n      = sym_cnt;
        bit_n      = bit_cnt;
        tx_n       = tx_bit;
        crc_n      = crc;
        w_n        = w;
        busy_n     = busy;
        done_n     = 1'b0;
        len_err_n  = 1'b0;
        load       = 1'b0;
        finish     = 1'b0;
        emit_state = state;
        emit_idx   = bit_cnt + BIT_W'(1);

        // Which symbol comes next once the current one completes.
        case (state)
            PREAMBLE: if (bit_cnt == BIT_W'(7))  begin emit_state = ACCESS; emit_idx = '0; end
            ACCESS:   if (bit_cnt == BIT_W'(31)) begin emit_state = PDU;    emit_idx = '0; end
            PDU:      if (bit_cnt == pdu_last)   begin emit_state = CRC;    emit_idx = '0; end
            CRC:      if (bit_cnt == BIT_W'(23)) finish = 1'b1;
            default:  ;
        endcase

        if (state == IDLE) begin
            if (start) begin
                if (len_ok) begin
                    load    = 1'b1;
                    state_n = PREAMBLE;
                    busy_n  = 1'b1;
                    sym_n   = '0;
                    bit_n   = '0;
                    tx_n    = acc_addr[0];
                    crc_n   = crc_init;
                    w_n     = {1'b1, channel};
                end else begin
                    len_err_n = 1'b1;
                end
            end
        end else begin
            sym_n = sym_last ? '0 : sym_cnt + SYM_W'(1);
            if (sym_last) begin
                if (finish) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    tx_n    = 1'b0;
                    bit_n   = '0;
                end else begin
                    state_n = emit_state;
                    bit_n   = emit_idx;
                    // CRC and whitener step together with each emitted PDU/CRC symbol.
                    case (emit_state)
                        PREAMBLE: tx_n = aa_q[0] ^ emit_idx[0];
                        ACCESS:   tx_n = aa_q[emit_idx[4:0]];
                        PDU: begin
                            tx_n  = pdu_d ^ w[0];
                            crc_n = crc_shift ^ ((crc[23] ^ pdu_d) ? POLY : 24'h0);
                            w_n   = w_adv;
                        end
                        CRC: begin
                            tx_n  = crc[23] ^ w[0];
                            crc_n = crc_shift;
                            w_n   = w_adv;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            sym_cnt <= '0;
            bit_cnt <= '0;
            aa_q    <= '0;
            pdu_q   <= '0;
            len_q   <= '0;
            crc     <= '0;
            w       <= '0;
            tx_bit  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            len_err <= 1'b0;
        end else if (en) begin
            state   <= state_n;
            sym_cnt <= sym_n;
            bit_cnt <= bit_n;
            crc     <= crc_n;
            w       <= w_n;
            tx_bit  <= tx_n;
            busy    <= busy_n;
            done    <= done_n;
            len_err <= len_err_n;
            if (load) begin
                aa_q  <= acc_addr;
                pdu_q <= pdu_in;
                len_q <= pdu_len;
            end
        end
    end

endmodule

// File: tb/tb_ble_packet_tx.sv
// Self-checking bench for ble_packet_tx: a symbol-list packet model drives a per-cycle
// compare of every output, plus directed timing, length-error, enable and reset checks.
module tb_ble_packet_tx;

    localparam int SR   = 16;
    localparam int MAXB = 39;
    localparam int PW   = 8 * MAXB;

    logic          clk      = 1'b0;
    logic          resetn   = 1'b1;
    logic          en       = 1'b1;
    logic          start    = 1'b0;
    logic [31:0]   acc_addr = '0;
    logic [5:0]    channel  = '0;
    logic [23:0]   crc_init = '0;
    logic [PW-1:0] pdu_in   = '0;
    logic [5:0]    pdu_len  = '0;
    logic          busy, tx_bit, tx_sym_clk, done, len_err;

    ble_packet_tx #(.SAMPLE_RATE(SR), .MAX_PDU_BYTES(MAXB)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .start      (start),
        .acc_addr   (acc_addr),
        .channel    (channel),
        .crc_init   (crc_init),
        .pdu_in     (pdu_in),
        .pdu_len    (pdu_len),
        .busy       (busy),
        .tx_bit     (tx_bit),
        .tx_sym_clk (tx_sym_clk),
        .done       (done),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Packet model: the full on-air symbol list computed straight from the packet rules.
    bit bld_q[$];

    task automatic build_syms(input logic [31:0] aa, input logic [5:0] ch, input logic [23:0] ci,
                              input logic [PW-1:0] pdu, input int len);
        logic [23:0] c;
        logic [6:0]  w;
        logic        d;
        bld_q.delete();
        for (int k = 0; k < 8; k++) bld_q.push_back(aa[0] ^ k[0]);
        for (int k = 0; k < 32; k++) bld_q.push_back(aa[k]);
        c = ci;
        w = {1'b1, ch};
        for (int i = 0; i < 8 * len; i++) begin
            d = pdu[i];
            bld_q.push_back(d ^ w[0]);
            c = {c[22:0], 1'b0} ^ ((c[23] ^ d) ? 24'h00065B : 24'h0);
            w = (w >> 1) ^ (w[0] ? 7'h44 : 7'h00);
        end
        for (int k = 23; k >= 0; k--) begin
            bld_q.push_back(c[k] ^ w[0]);
            w = (w >> 1) ^ (w[0] ? 7'h44 : 7'h00);
        end
    endtask

    function automatic logic [7:0] bld_byte(input int base);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = bld_q[base + k];
        return b;
    endfunction

    function automatic logic [PW-1:0] make_pdu(input int seed, input int len);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < len; i++) p[i*8 +: 8] = 8'(i * seed + 3 * seed + 1);
        return p;
    endfunction

    // Timeline model: m_n counts enabled clocks since the accepting edge.
    bit m_sym[$];
    bit m_active  = 1'b0;
    bit m_done    = 1'b0;
    bit m_len_err = 1'b0;
    int m_n       = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_len_err = 1'b0;
            m_n       = 0;
        end else if (en) begin
            m_done    = 1'b0;
            m_len_err = 1'b0;
            if (m_active) begin
                m_n++;
                if (m_n == m_sym.size() * SR) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end else if (start) begin
                if (pdu_len >= 6'd2 && pdu_len <= 6'(MAXB)) begin
                    build_syms(acc_addr, channel, crc_init, pdu_in, int'(pdu_len));
                    m_sym    = bld_q;
                    m_active = 1'b1;
                    m_n      = 0;
                end else begin
                    m_len_err = 1'b1;
                end
            end
        end
    end

    bit   cmp_en = 1'b0;
    int   busy_cnt = 0, edge_cnt = 0, done_cnt = 0;
    logic prev_sc = 1'b0;
    logic e_bit, e_sc;

    always @(negedge clk) begin
        if (cmp_en) begin
            e_bit = m_active ? m_sym[m_n / SR] : 1'b0;
            e_sc  = m_active && ((m_n % SR) < SR / 2);
            chk("busy", busy, m_active);
            chk("tx_bit", tx_bit, e_bit);
            chk("tx_sym_clk", tx_sym_clk, e_sc);
            chk("done", done, m_done);
            chk("len_err", len_err, m_len_err);
        end
        if (busy === 1'b1) busy_cnt++;
        if (tx_sym_clk === 1'b1 && prev_sc !== 1'b1) edge_cnt++;
        prev_sc = tx_sym_clk;
        if (done === 1'b1) done_cnt++;
    end

    task automatic send_pkt(input logic [31:0] aa, input logic [5:0] ch, input logic [23:0] ci,
                            input logic [PW-1:0] pdu, input logic [5:0] len);
        acc_addr = aa;
        channel  = ch;
        crc_init = ci;
        pdu_in   = pdu;
        pdu_len  = len;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(k < budget), 32'd1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_tx_bit"}, tx_bit, 1'b0);
        chk({tag, "_sym_clk"}, tx_sym_clk, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_len_err"}, len_err, 1'b0);
    endtask

    task automatic bad_len(input logic [5:0] len);
        pdu_len = len;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("len_err_pulse", len_err, 1'b1);
        chk("len_err_busy", busy, 1'b0);
        @(negedge clk);
        chk("len_err_clear", len_err, 1'b0);
        chk("len_err_idle", busy, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int b0, e0, d0;

    initial begin
        // Hand-computed expectations that pin the packet model itself.
        build_syms(32'h6b7d9171, 6'd37, 24'h555555, '0, 2);
        chk("pin_len80", bld_q.size(), 80);
        chk("pin_pre55", bld_byte(0), 8'h55);
        chk("pin_aa71", bld_byte(8), 8'h71);
        chk("pin_wht37", bld_byte(40), 8'h8D);
        build_syms(32'h8E89BED6, 6'd0, 24'h555555, '0, 2);
        chk("pin_preAA", bld_byte(0), 8'hAA);
        chk("pin_aaD6", bld_byte(8), 8'hD6);
        chk("pin_wht0", bld_byte(40), 8'h40);

        // Clock/reset.
        #2 resetn = 1'b0;
        #1 chk_outputs_zero("reset");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;

        // Header-only packet, then a back-to-back start with a start-while-busy attempt.
        b0 = busy_cnt; e0 = edge_cnt; d0 = done_cnt;
        send_pkt(32'h6b7d9171, 6'd37, 24'h555555, make_pdu(7, 2), 6'd2);
        wait_done("a_done_timeout", 2000);
        chk("a_busy_clocks", busy_cnt - b0, 1280);
        chk("a_sym_edges", edge_cnt - e0, 80);
        b0 = busy_cnt;
        send_pkt(32'h8E89BED6, 6'd0, 24'h555555, make_pdu(29, 20), 6'd20);
        chk("a_done_once", done_cnt - d0, 1);
        chk("b2b_busy", busy, 1'b1);
        repeat (20 * SR) @(negedge clk);
        acc_addr = 32'hDEADBEEF;
        pdu_len  = 6'd5;
        start    = 1'b1;
        repeat (2) @(negedge clk);
        start    = 1'b0;
        wait_done("b_done_timeout", 5000);
        chk("b_busy_clocks", busy_cnt - b0, (64 + 160) * SR);

        // Out-of-range lengths.
        @(negedge clk);
        bad_len(6'd1);
        bad_len(6'd40);
        bad_len(6'd0);

        // Enable held low for 7 clocks in the middle of the PDU.
        b0 = busy_cnt;
        send_pkt(32'h6b7d9171, 6'd12, 24'h555555, make_pdu(13, 20), 6'd20);
        repeat (45 * SR) @(negedge clk);
        en = 1'b0;
        repeat (7) @(negedge clk);
        en = 1'b1;
        wait_done("en_done_timeout", 5000);
        chk("en_busy_clocks", busy_cnt - b0, (64 + 160) * SR + 7);

        // Reset during the CRC field, then a full packet.
        @(negedge clk);
        d0 = done_cnt;
        send_pkt(32'h6b7d9171, 6'd39, 24'h555555, make_pdu(5, 2), 6'd2);
        repeat (1000) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        #3 resetn = 1'b0;
        #1 chk_outputs_zero("abort");
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        b0 = busy_cnt;
        send_pkt(32'h6b7d9171, 6'd39, 24'h555555, make_pdu(11, 20), 6'd20);
        wait_done("post_reset_done_timeout", 5000);
        chk("post_reset_busy_clocks", busy_cnt - b0, (64 + 160) * SR);

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
